memarb: RTL and testbench

Single-port memory arbiter for the minimal EDSAC. Shares the one memory port between three requesters: the initial-orders loader (init), the CPU, and the tape/teleprinter I/O engine (io). After reset it grants the port exclusively to init until the initial orders are loaded, then alternates round-robin between cpu and io. It holds a grant across downstream stalls and routes read data back to the owner.

---
 rtl/memarb.sv | 163 ++++++++++++++++
 tb/tb_memarb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memarb.sv
// Single-port memory arbiter: init loader owns the port until the initial orders
// are loaded, then cpu and io share it round-robin with stall locking.
module memarb #(
    parameter int ABITS = 9,
    parameter int DBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ABITS-1:0] init_addr,
    input  logic [DBITS-1:0] init_wdata,
    input  logic             init_wr,
    output logic             init_wait,
    input  logic [ABITS-1:0] cpu_addr,
    input  logic [DBITS-1:0] cpu_wdata,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    output logic             cpu_wait,
    output logic             cpu_rvalid,
    input  logic [ABITS-1:0] io_addr,
    input  logic [DBITS-1:0] io_wdata,
    input  logic             io_rd,
    input  logic             io_wr,
    output logic             io_wait,
    output logic             io_rvalid,
    output logic [DBITS-1:0] rdata,
    output logic [ABITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic             mem_wait,
    input  logic [DBITS-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_seen;
    logic   r_lock_vld;
    logic   r_lock_own;
    logic   r_last;
    logic   r_cpu_rvalid;
    logic   r_io_rvalid;

    logic   w_cpu_req;
    logic   w_io_req;
    logic   w_gnt_vld;
    logic   w_gnt_own;
    logic   w_acc;
    logic   w_init_acc;

    assign w_cpu_req = cpu_rd | cpu_wr;
    assign w_io_req  = io_rd | io_wr;

    // Grant selection: a locked (stalled) owner is never pre-empted.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_own = OWN_CPU;
        if (rst || (r_state == ST_INIT)) begin
            w_gnt_vld = 1'b0;
        end else if (r_lock_vld) begin
            w_gnt_vld = 1'b1;
            w_gnt_own = r_lock_own;
        end else if (w_cpu_req && w_io_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_own = ~r_last;
        end else if (w_cpu_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_own = OWN_CPU;
        end else if (w_io_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_own = OWN_IO;
        end else begin
            w_gnt_vld = 1'b0;
        end
    end

    // Memory port mux; a simultaneous rd+wr is issued as a write only.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (rst) begin
            mem_rd = 1'b0;
        end else if (r_state == ST_INIT) begin
            mem_addr  = init_addr;
            mem_wdata = init_wdata;
            mem_wr    = init_wr;
        end else if (w_gnt_vld && (w_gnt_own == OWN_IO)) begin
            mem_addr  = io_addr;
            mem_wdata = io_wdata;
            mem_wr    = io_wr;
            mem_rd    = io_rd & ~io_wr;
        end else if (w_gnt_vld) begin
            mem_wr = cpu_wr;
            mem_rd = cpu_rd & ~cpu_wr;
        end else begin
            mem_wr = 1'b0;
        end
    end

    assign w_acc      = w_gnt_vld & ~mem_wait;
    assign w_init_acc = ~rst & (r_state == ST_INIT) & init_wr & ~mem_wait;

    assign cpu_wait   = w_cpu_req & ~(w_acc & (w_gnt_own == OWN_CPU));
    assign io_wait    = w_io_req & ~(w_acc & (w_gnt_own == OWN_IO));
    assign init_wait  = init_wr & ~w_init_acc;

    assign cpu_rvalid = r_cpu_rvalid & ~rst;
    assign io_rvalid  = r_io_rvalid & ~rst;
    assign rdata      = mem_rdata;

    // Leave INIT once loading has happened and the loader goes quiet.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_seen && !init_wr) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // State, lock, round-robin history and read-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_seen       <= 1'b0;
            r_lock_vld   <= 1'b0;
            r_lock_own   <= OWN_CPU;
            r_last       <= OWN_IO;
            r_cpu_rvalid <= 1'b0;
            r_io_rvalid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_init_acc) begin
                r_seen <= 1'b1;
            end
            if (w_acc) begin
                r_lock_vld <= 1'b0;
                r_last     <= w_gnt_own;
            end else if (w_gnt_vld && mem_wait) begin
                r_lock_vld <= 1'b1;
                r_lock_own <= w_gnt_own;
            end
            r_cpu_rvalid <= w_acc & (w_gnt_own == OWN_CPU) & cpu_rd & ~cpu_wr;
            r_io_rvalid  <= w_acc & (w_gnt_own == OWN_IO) & io_rd & ~io_wr;
        end
    end

endmodule

// File: tb/tb_memarb.sv
// Directed bench for memarb: init load, round-robin reads, stall lock,
// rd+wr collision, idle RUN and reset under lock.
module tb_memarb;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  init_addr;
    logic [15:0] init_wdata;
    logic        init_wr;
    logic        init_wait;
    logic [8:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_wait;
    logic        cpu_rvalid;
    logic [8:0]  io_addr;
    logic [15:0] io_wdata;
    logic        io_rd;
    logic        io_wr;
    logic        io_wait;
    logic        io_rvalid;
    logic [15:0] rdata;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_wait;
    logic [15:0] mem_rdata = 16'h0000;

    int checks   = 0;
    int failures = 0;

    memarb #(.ABITS(9), .DBITS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_addr  (init_addr),
        .init_wdata (init_wdata),
        .init_wr    (init_wr),
        .init_wait  (init_wait),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_wait   (cpu_wait),
        .cpu_rvalid (cpu_rvalid),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .io_wait    (io_wait),
        .io_rvalid  (io_rvalid),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wait   (mem_wait),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: a read of address A returns 0xA000 | A on the next cycle.
    always @(posedge clk) begin
        if (mem_rd && !mem_wait) mem_rdata <= 16'hA000 | {7'd0, mem_addr};
        else                     mem_rdata <= 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; mem_wait = 1'b0;
        init_addr = 9'd0; init_wdata = 16'd0; init_wr = 1'b0;
        cpu_addr = 9'd7; cpu_wdata = 16'd0; cpu_rd = 1'b1; cpu_wr = 1'b0;
        io_addr = 9'd0; io_wdata = 16'd0; io_rd = 1'b0; io_wr = 1'b0;
        tick(); tick(); settle();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd1);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_io_rvalid", 32'(io_rvalid), 32'd0);

        // Initial orders: 38 writes while cpu_rd is held.
        rst = 1'b0;
        for (int i = 0; i < 38; i++) begin
            init_wr = 1'b1; init_addr = 9'(i); init_wdata = 16'h0100 + 16'(i);
            settle();
            chk("init_mem_wr", 32'(mem_wr), 32'd1);
            chk("init_mem_rd", 32'(mem_rd), 32'd0);
            chk("init_mem_addr", 32'(mem_addr), 32'(i));
            chk("init_mem_wdata", 32'(mem_wdata), 32'h0100 + 32'(i));
            chk("init_cpu_wait", 32'(cpu_wait), 32'd1);
            chk("init_init_wait", 32'(init_wait), 32'd0);
            tick();
        end
        init_wr = 1'b0; settle();
        chk("initend_mem_wr", 32'(mem_wr), 32'd0);
        chk("initend_mem_rd", 32'(mem_rd), 32'd0);
        chk("initend_cpu_wait", 32'(cpu_wait), 32'd1);
        tick(); settle();
        chk("run1_mem_rd", 32'(mem_rd), 32'd1);
        chk("run1_mem_addr", 32'(mem_addr), 32'd7);
        chk("run1_cpu_wait", 32'(cpu_wait), 32'd0);
        tick();
        chk("run1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("run1_rdata", 32'(rdata), 32'hA007);

        // io alone, so that the contention run starts with cpu.
        cpu_rd = 1'b0; io_rd = 1'b1; io_addr = 9'd3; settle();
        chk("ioalone_mem_addr", 32'(mem_addr), 32'd3);
        chk("ioalone_io_wait", 32'(io_wait), 32'd0);
        tick();
        chk("ioalone_io_rvalid", 32'(io_rvalid), 32'd1);
        chk("ioalone_rdata", 32'(rdata), 32'hA003);

        // Continuous contention: cpu10, io20, cpu11, io21.
        cpu_rd = 1'b1; cpu_addr = 9'd10; io_addr = 9'd20; settle();
        chk("rr1_mem_addr", 32'(mem_addr), 32'd10);
        chk("rr1_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rr1_io_wait", 32'(io_wait), 32'd1);
        tick();
        chk("rr1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rr1_io_rvalid", 32'(io_rvalid), 32'd0);
        chk("rr1_rdata", 32'(rdata), 32'hA00A);
        cpu_addr = 9'd11; settle();
        chk("rr2_mem_addr", 32'(mem_addr), 32'd20);
        chk("rr2_cpu_wait", 32'(cpu_wait), 32'd1);
        chk("rr2_io_wait", 32'(io_wait), 32'd0);
        tick();
        chk("rr2_io_rvalid", 32'(io_rvalid), 32'd1);
        chk("rr2_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rr2_rdata", 32'(rdata), 32'hA014);
        io_addr = 9'd21; settle();
        chk("rr3_mem_addr", 32'(mem_addr), 32'd11);
        chk("rr3_io_wait", 32'(io_wait), 32'd1);
        tick();
        chk("rr3_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rr3_rdata", 32'(rdata), 32'hA00B);
        cpu_rd = 1'b0; settle();
        chk("rr4_mem_addr", 32'(mem_addr), 32'd21);
        chk("rr4_io_wait", 32'(io_wait), 32'd0);
        tick();
        chk("rr4_io_rvalid", 32'(io_rvalid), 32'd1);
        chk("rr4_rdata", 32'(rdata), 32'hA015);

        // Idle RUN; init is ignored and only stalls itself.
        io_rd = 1'b0; init_wr = 1'b1; settle();
        chk("idle_mem_rd", 32'(mem_rd), 32'd0);
        chk("idle_mem_wr", 32'(mem_wr), 32'd0);
        chk("idle_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("idle_io_wait", 32'(io_wait), 32'd0);
        chk("idle_init_wait", 32'(init_wait), 32'd1);
        tick();

        // io write stalls 3 cycles; cpu joins and would win a tie, but the lock holds.
        init_wr = 1'b0; io_wr = 1'b1; io_addr = 9'd40; io_wdata = 16'hBEEF; mem_wait = 1'b1;
        settle();
        chk("stall0_mem_wr", 32'(mem_wr), 32'd1);
        chk("stall0_mem_addr", 32'(mem_addr), 32'd40);
        chk("stall0_io_wait", 32'(io_wait), 32'd1);
        tick();
        cpu_rd = 1'b1; cpu_addr = 9'd31;
        for (int k = 1; k < 3; k++) begin
            settle();
            chk("stall_mem_addr", 32'(mem_addr), 32'd40);
            chk("stall_mem_wr", 32'(mem_wr), 32'd1);
            chk("stall_mem_rd", 32'(mem_rd), 32'd0);
            chk("stall_io_wait", 32'(io_wait), 32'd1);
            chk("stall_cpu_wait", 32'(cpu_wait), 32'd1);
            tick();
        end
        mem_wait = 1'b0; settle();
        chk("stall3_mem_addr", 32'(mem_addr), 32'd40);
        chk("stall3_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("stall3_io_wait", 32'(io_wait), 32'd0);
        chk("stall3_cpu_wait", 32'(cpu_wait), 32'd1);
        tick();
        io_wr = 1'b0; settle();
        chk("after_mem_addr", 32'(mem_addr), 32'd31);
        chk("after_mem_rd", 32'(mem_rd), 32'd1);
        chk("after_cpu_wait", 32'(cpu_wait), 32'd0);
        tick();
        chk("after_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("after_io_rvalid", 32'(io_rvalid), 32'd0);
        chk("after_rdata", 32'(rdata), 32'hA01F);

        // Idle cycle must not touch last: the next tie goes to io.
        cpu_rd = 1'b0; tick();
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 9'd5; cpu_wdata = 16'h1234;
        io_rd = 1'b1; io_addr = 9'd50; settle();
        chk("last_mem_addr", 32'(mem_addr), 32'd50);
        chk("last_cpu_wait", 32'(cpu_wait), 32'd1);
        tick();
        chk("last_io_rvalid", 32'(io_rvalid), 32'd1);
        chk("last_rdata", 32'(rdata), 32'hA032);
        io_rd = 1'b0; settle();
        chk("rdwr_mem_wr", 32'(mem_wr), 32'd1);
        chk("rdwr_mem_rd", 32'(mem_rd), 32'd0);
        chk("rdwr_mem_addr", 32'(mem_addr), 32'd5);
        chk("rdwr_mem_wdata", 32'(mem_wdata), 32'h1234);
        chk("rdwr_cpu_wait", 32'(cpu_wait), 32'd0);
        tick();
        chk("rdwr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

        // Reset while io is stalled under lock.
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        io_wr = 1'b1; io_addr = 9'd60; io_wdata = 16'h7777; mem_wait = 1'b1; settle();
        chk("prerst_io_wait", 32'(io_wait), 32'd1);
        chk("prerst_mem_wr", 32'(mem_wr), 32'd1);
        tick();
        rst = 1'b1; cpu_rd = 1'b1; cpu_addr = 9'd8; settle();
        chk("inrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("inrst_mem_rd", 32'(mem_rd), 32'd0);
        chk("inrst_io_wait", 32'(io_wait), 32'd1);
        chk("inrst_cpu_wait", 32'(cpu_wait), 32'd1);
        tick();
        rst = 1'b0; mem_wait = 1'b0; settle();
        chk("postrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("postrst_mem_rd", 32'(mem_rd), 32'd0);
        chk("postrst_io_wait", 32'(io_wait), 32'd1);
        chk("postrst_cpu_wait", 32'(cpu_wait), 32'd1);
        chk("postrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("postrst_io_rvalid", 32'(io_rvalid), 32'd0);
        tick();
        init_wr = 1'b1; init_addr = 9'd0; init_wdata = 16'h0042; settle();
        chk("reinit_mem_wr", 32'(mem_wr), 32'd1);
        chk("reinit_mem_wdata", 32'(mem_wdata), 32'h0042);
        chk("reinit_cpu_wait", 32'(cpu_wait), 32'd1);
        tick();
        init_wr = 1'b0; settle();
        chk("reinitend_cpu_wait", 32'(cpu_wait), 32'd1);
        chk("reinitend_mem_rd", 32'(mem_rd), 32'd0);
        tick(); settle();
        chk("rerun_mem_rd", 32'(mem_rd), 32'd1);
        chk("rerun_mem_addr", 32'(mem_addr), 32'd8);
        chk("rerun_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rerun_io_wait", 32'(io_wait), 32'd1);
        tick();
        chk("rerun_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rerun_rdata", 32'(rdata), 32'hA008);
        cpu_rd = 1'b0; settle();
        chk("rerun_io_mem_wr", 32'(mem_wr), 32'd1);
        chk("rerun_io_mem_addr", 32'(mem_addr), 32'd60);
        chk("rerun_io_mem_wdata", 32'(mem_wdata), 32'h7777);
        chk("rerun_io_wait", 32'(io_wait), 32'd0);
        tick();
        io_wr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
